// File: rtl/product_accumulator_pkg.sv
// Shared state encoding and default widths for the product accumulator.
// Optional saturation is selected with ACC_SATURATE_EN (see acc_add_sat).
package pkg_product_acc;

    localparam int unsigned SIZE        = 16;
    localparam int unsigned ACC_WIDTH   = 40;
    localparam int unsigned COUNT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_HOLD  = 2'b10
    } state_t;

endpackage

// File: rtl/product_accumulator_acc_add_sat.sv
// Combinational accumulator adder with carry-out.
// Defining ACC_SATURATE_EN clamps the sum to all-ones on carry; otherwise it wraps.
module acc_add_sat
    import pkg_product_acc::*;
#(
    parameter int unsigned PROD_WIDTH = 32,
    parameter int unsigned ACC_WIDTH  = 40
) (
    input  logic [ACC_WIDTH-1:0]  acc,
    input  logic [PROD_WIDTH-1:0] product,
    output logic [ACC_WIDTH-1:0]  sum,
    output logic                  carry
);

    logic [ACC_WIDTH:0] sum_wide;

    assign sum_wide = {1'b0, acc} + (ACC_WIDTH+1)'(product);
    assign carry    = sum_wide[ACC_WIDTH];

`ifdef ACC_SATURATE_EN
    assign sum = carry ? {ACC_WIDTH{1'b1}} : sum_wide[ACC_WIDTH-1:0];
`else
    assign sum = sum_wide[ACC_WIDTH-1:0];
`endif

endmodule

// File: rtl/product_accumulator.sv
// Accumulates a programmed number of unsigned multiplier products and presents
// the sum on a valid/ready port. ACC_SATURATE_EN selects clamping instead of wrap.
module product_accumulator
    import pkg_product_acc::*;
#(
    parameter int unsigned SIZE        = pkg_product_acc::SIZE,
    parameter int unsigned ACC_WIDTH   = pkg_product_acc::ACC_WIDTH,
    parameter int unsigned COUNT_WIDTH = pkg_product_acc::COUNT_WIDTH
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   iStart,
    input  logic [COUNT_WIDTH-1:0] iLength,
    input  logic                   iProductValid,
    input  logic [2*SIZE-1:0]      iProduct,
    output logic                   oProductReady,
    output logic [ACC_WIDTH-1:0]   oResult,
    output logic                   oResultValid,
    input  logic                   iResultReady,
    output logic                   oBusy,
    output logic                   oOverflow
);

    localparam int unsigned PROD_WIDTH = 2 * SIZE;

    state_t                 state;
    logic [COUNT_WIDTH-1:0] count;
    logic [COUNT_WIDTH-1:0] length;
    logic [ACC_WIDTH-1:0]   add_sum;
    logic                   add_carry;
    logic                   transfer;
    logic                   last_product;

    assign oProductReady = (state == ST_ACCUM);
    assign oBusy         = (state != ST_IDLE);
    assign transfer      = iProductValid & oProductReady;
    assign last_product  = (count == length - COUNT_WIDTH'(1));

    acc_add_sat #(
        .PROD_WIDTH (PROD_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_add (
        .acc     (oResult),
        .product (iProduct),
        .sum     (add_sum),
        .carry   (add_carry)
    );

    // oResult doubles as the accumulator; it is final only while oResultValid is high
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= ST_IDLE;
            oResult      <= '0;
            oResultValid <= 1'b0;
            oOverflow    <= 1'b0;
            count        <= '0;
            length       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (iStart) begin
                        length    <= iLength;
                        oResult   <= '0;
                        count     <= '0;
                        oOverflow <= 1'b0;
                        if (iLength == '0) begin
                            state        <= ST_HOLD;
                            oResultValid <= 1'b1;
                        end else begin
                            state <= ST_ACCUM;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (transfer) begin
                        oResult <= add_sum;
                        count   <= count + COUNT_WIDTH'(1);
                        if (add_carry) begin
                            oOverflow <= 1'b1;
                        end
                        if (last_product) begin
                            state        <= ST_HOLD;
                            oResultValid <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (iResultReady) begin
                        state        <= ST_IDLE;
                        oResultValid <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    oResultValid <= 1'b0;
                end
            endcase
        end
    end

endmodule
